// File: rtl/bridge_byte_reader_if.sv
// Bridge read port plus byte-wide memory read port for bridge_byte_reader.
// slave is the reader's view; master is the host and memory side.
interface bridge_byte_reader_if #(
    parameter int ADDR_WIDTH = 25
);
    logic [31:0]           bridge_addr;
    logic                  bridge_rd;
    logic [31:0]           bridge_rd_data;
    logic                  bridge_rd_valid;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [7:0]            mem_rd_data;

    modport slave (
        input  bridge_addr,
        input  bridge_rd,
        input  mem_rd_data,
        output bridge_rd_data,
        output bridge_rd_valid,
        output busy,
        output mem_addr,
        output mem_rd
    );

    modport master (
        output bridge_addr,
        output bridge_rd,
        output mem_rd_data,
        input  bridge_rd_data,
        input  bridge_rd_valid,
        input  busy,
        input  mem_addr,
        input  mem_rd
    );
endinterface

// File: rtl/bridge_byte_reader.sv
// Assembles a big-endian 32-bit bridge read from four byte reads of a fixed-latency memory.
// Define BRIDGE_BYTE_READER_PIPELINE_EN to issue the four byte reads back to back.
module bridge_byte_reader #(
    parameter int ADDR_WIDTH = 25,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    bridge_byte_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  valid_q, valid_d;
    logic                  cap_fire;
    logic [1:0]            cap_lane;

    // Word alignment means base+3 never carries, so bits [1:0] and anything above the port are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.bridge_addr[31:ADDR_WIDTH], bus.bridge_addr[1:0]};

`ifdef BRIDGE_BYTE_READER_PIPELINE_EN
    // Each issued read carries its lane tag down a LATENCY-deep shift, landing with its byte.
    logic [LATENCY-1:0]      tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0][1:0] tag_lane_q, tag_lane_d;

    assign tag_vld_d[0]  = (state_q == ISSUE);
    assign tag_lane_d[0] = idx_q;

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign tag_vld_d[gi]  = tag_vld_q[gi-1];
            assign tag_lane_d[gi] = tag_lane_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q  <= '0;
            tag_lane_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_lane_q <= tag_lane_d;
        end
    end

    assign cap_fire = tag_vld_q[LATENCY-1];
    assign cap_lane = tag_lane_q[LATENCY-1];
`else
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Counter is loaded at the issue edge, so a value of 1 marks the sampling edge.
    assign cap_fire = (state_q == WAIT) && (cnt_q == 4'd1);
    assign cap_lane = idx_q;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mem_addr_d = mem_addr_q;
        word_d     = word_q;
        rd_data_d  = rd_data_q;
        valid_d    = 1'b0;
`ifndef BRIDGE_BYTE_READER_PIPELINE_EN
        cnt_d      = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
`endif

        if (cap_fire) begin
            case (cap_lane)
                2'd0:    word_d[31:24] = bus.mem_rd_data;
                2'd1:    word_d[23:16] = bus.mem_rd_data;
                2'd2:    word_d[15:8]  = bus.mem_rd_data;
                default: word_d[7:0]   = bus.mem_rd_data;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (bus.bridge_rd) begin
                    mem_addr_d = {bus.bridge_addr[ADDR_WIDTH-1:2], 2'b00};
                    idx_d      = 2'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
`ifdef BRIDGE_BYTE_READER_PIPELINE_EN
                if (idx_q == 2'd3) begin
                    state_d = WAIT;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                end
`else
                cnt_d   = LAT4;
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (cap_fire) begin
                    if (cap_lane == 2'd3) begin
                        rd_data_d = word_d;
                        valid_d   = 1'b1;
                        state_d   = DONE;
                    end else begin
`ifndef BRIDGE_BYTE_READER_PIPELINE_EN
                        idx_d      = idx_q + 2'd1;
                        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                        state_d    = ISSUE;
`endif
                    end
                end
            end
            DONE: begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            mem_addr_q <= '0;
            word_q     <= '0;
            rd_data_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mem_addr_q <= mem_addr_d;
            word_q     <= word_d;
            rd_data_q  <= rd_data_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.bridge_rd_data  = rd_data_q;
    assign bus.bridge_rd_valid = valid_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_rd          = (state_q == ISSUE);
endmodule
